// File: rtl/nes_pkg.sv
// Shared types and constants for the save-RAM uploader: the state encoding,
// the SDRAM byte-address width and the read-acknowledge timeout.
package nes_pkg;

  localparam int ADDR_W      = 22;
  localparam int MEM_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/save_uploader.sv
// Streams a block of SDRAM bytes to the HPS one byte at a time.
// Reads go out only in the memory slot, and a running checksum is kept of every byte the host consumes.
module save_uploader
  import nes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic              mem_slot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              upload_active,
  output logic              upload_valid,
  output logic [7:0]        upload_data,
  input  logic              host_rd,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic [7:0]        r_timeout;
  logic [7:0]        r_data;
  logic [7:0]        r_checksum;
  logic              w_idle_like;
  logic              w_accept;
  logic              w_consume;
  logic              w_timeout_hit;

  assign w_idle_like   = (r_state == IDLE) || (r_state == DONE) || (r_state == ERROR);
  assign w_accept      = start && w_idle_like;
  assign w_consume     = (r_state == HOLD) && host_rd;
  // The counter holds the number of WAIT cycles already spent.
  assign w_timeout_hit = (r_timeout == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    mem_read      = 1'b0;
    upload_active = 1'b0;
    upload_valid  = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = (length == 16'd0) ? DONE : FETCH;
      end
      FETCH: begin
        upload_active = 1'b1;
        mem_read      = mem_slot;
        if (mem_slot) w_state_next = WAIT;
      end
      WAIT: begin
        upload_active = 1'b1;
        if (mem_ack)            w_state_next = HOLD;
        else if (w_timeout_hit) w_state_next = ERROR;
      end
      HOLD: begin
        upload_active = 1'b1;
        upload_valid  = 1'b1;
        if (host_rd) w_state_next = (r_count == 16'd1) ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_next = (length == 16'd0) ? DONE : FETCH;
      end
      ERROR: begin
        error = 1'b1;
        if (start) w_state_next = (length == 16'd0) ? DONE : FETCH;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_timeout  <= '0;
      r_data     <= '0;
      r_checksum <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= base_addr;
        r_count    <= length;
        r_checksum <= '0;
      end
      if (r_state == FETCH) begin
        r_timeout <= '0;
      end else if (r_state == WAIT) begin
        r_timeout <= r_timeout + 8'd1;
      end
      if ((r_state == WAIT) && mem_ack) begin
        r_data <= mem_data;
      end
      // Address wraps naturally at the register width.
      if (w_consume) begin
        r_checksum <= r_checksum + r_data;
        r_addr     <= r_addr + ADDR_W'(1);
        r_count    <= r_count - 16'd1;
      end
    end
  end

  assign mem_addr    = r_addr;
  assign upload_data = r_data;
  assign checksum    = r_checksum;

endmodule

// File: doc/save_uploader.md
SAVE_UPLOADER -- requirements
Module: save_uploader

Interface
REQ-001 clk  input  1  system clock; all logic is on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse that begins an upload; honoured only in IDLE, DONE or ERROR.
REQ-004 base_addr  input  22  first memory byte address, sampled on an accepted start.
REQ-005 length  input  16  byte count, sampled on an accepted start; 0 means an empty upload.
REQ-006 mem_slot  input  1  memory arbitration slot (the nes_ce==3 phase); a read may be issued only while it is high.
REQ-007 mem_addr  output  22  read address presented to the SDRAM port.
REQ-008 mem_read  output  1  single-cycle read request.
REQ-009 mem_ack  input  1  single-cycle indication that mem_data is valid.
REQ-010 mem_data  input  8  read data, valid on mem_ack.
REQ-011 upload_active  output  1  high from an accepted start until DONE or ERROR.
REQ-012 upload_valid  output  1  upload_data holds an unconsumed byte.
REQ-013 upload_data  output  8  current byte for the HPS.
REQ-014 host_rd  input  1  one-cycle pulse from the HPS that consumes the current byte.
REQ-015 done  output  1  all bytes delivered; held until the next accepted start or reset.
REQ-016 error  output  1  memory timeout; held until the next accepted start or reset.
REQ-017 checksum  output  8  modulo-256 sum of the bytes consumed in the current upload.

Function
REQ-018 The state machine SHALL have six states: IDLE, FETCH, WAIT, HOLD, DONE and ERROR.
REQ-019 An accepted start SHALL load the address and remaining-count registers, clear checksum, done and error, and move to DONE when length is 0, otherwise to FETCH.
REQ-020 In FETCH, on the first cycle with mem_slot=1, the block SHALL pulse mem_read for exactly one cycle with mem_addr equal to the current address, then move to WAIT.
REQ-021 In WAIT, mem_ack SHALL latch mem_data into upload_data and move to HOLD; upload_valid rises on the following cycle.
REQ-022 WAIT SHALL count cycles; after 255 cycles without mem_ack the block SHALL move to ERROR.
REQ-023 In HOLD, host_rd SHALL clear upload_valid, add upload_data to checksum (8-bit wrap), increment the address, and decrement the remaining count.
REQ-024 From HOLD, if the count decremented to 0 the block SHALL move to DONE, otherwise to FETCH.
REQ-025 The address SHALL increment modulo 2^22, so 22'h3FFFFF wraps to 0.
REQ-026 host_rd SHALL be ignored outside HOLD, and start SHALL be ignored while in FETCH, WAIT or HOLD.
REQ-027 If mem_ack and host_rd arrive in the same cycle, each is handled by the current state only.
REQ-028 A stray mem_ack outside WAIT SHALL be ignored.
REQ-029 No more than one memory read SHALL be outstanding at any time.
REQ-030 upload_active SHALL equal the state being FETCH, WAIT or HOLD.

Reset
REQ-031 Reset SHALL force IDLE and zero all outputs: mem_addr, mem_read, upload_active, upload_valid, upload_data, done, error and checksum.
REQ-032 Reset asserted mid-upload SHALL abandon the upload; a mem_ack arriving after reset is ignored.

Structure
REQ-033 A shared package nes_pkg SHALL hold the state enum, the ADDR_W=22 constant and the MEM_TIMEOUT=255 constant.
REQ-034 No sub-module is needed; the block is a single module with one state machine, a 16-bit counter, a 22-bit address register and an 8-bit timeout counter.

Verification
REQ-035 base=22'h3C0000, length=4, memory returns 11,22,33,44 with ack 2 cycles after each read, host reads each byte -> four reads at 3C0000..3C0003, bytes delivered in order, done=1, checksum=8'hAA.
REQ-036 length=0 with a start pulse -> done=1 one cycle later, no mem_read issued, checksum=0.
REQ-037 mem_ack never arrives -> error=1 exactly 255 cycles after entering WAIT, upload_active=0.
REQ-038 base=22'h3FFFFF, length=2 -> reads issued at 3FFFFF then 000000.
REQ-039 mem_slot high only every 4th cycle -> every mem_read coincides with mem_slot=1; a host_rd while upload_valid=0 is ignored; a start while busy is ignored.
REQ-040 reset asserted while in WAIT, followed by a late mem_ack -> block in IDLE with all outputs 0; a new start then runs correctly.
